// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store initiator for the CPU memory stage. Takes one load or store at a
// time, runs the 32-bit memory read/write sequence on the unified byte-address
// memory port, and returns aligned, extended load data or a store completion.
// The memory always writes 4 bytes at address..address+3, so byte and
// halfword stores are done as a read-modify-write of that 4-byte window.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake, ready only while idle
//   req_write         : 1 = store, 0 = load
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr          : byte address, any alignment
//   req_wdata         : store data, low 8/16/32 bits used
//   resp_valid        : one-cycle response pulse
//   resp_rdata        : extended load data, 0 for stores and faults
//   resp_fault        : illegal size or out-of-range address
//   mem_address       : memory byte address (registered)
//   mem_data_in       : memory write data (registered)
//   mem_w_enable      : memory write enable (registered)
//   mem_data_out      : combinational memory read data, little-endian
// ---------------------------------------------------------------------------
module lsu_mem_port #(
    parameter logic [31:0] START_ADDR = 32'h01000000,
    parameter int unsigned MEM_SIZE   = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    input  logic [31:0] mem_data_out
);

    // Last valid byte address, kept 33 bits wide to match the range sum.
    localparam logic [32:0] LAST_ADDR = {1'b0, START_ADDR} + 33'(MEM_SIZE) - 33'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_fault;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_w_enable;

    logic [32:0] w_addr_end;
    logic        w_in_range;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // The 33-bit sum makes addresses near 32'hFFFFFFFF fault instead of
    // wrapping around into the valid window.
    assign w_addr_end = {1'b0, req_addr} + 33'd3;
    assign w_in_range = (req_addr >= START_ADDR) && (w_addr_end <= LAST_ADDR);
    assign w_fault    = !w_in_range || (req_size == 2'b11);

    // Load extension of the word read in RD. Size 11 never reaches RD.
    always_comb begin
        w_load_data = mem_data_out;
        case (r_size)
            2'b00: w_load_data = r_unsigned ? {24'h000000, mem_data_out[7:0]}
                                            : {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            2'b01: w_load_data = r_unsigned ? {16'h0000, mem_data_out[15:0]}
                                            : {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            default: w_load_data = mem_data_out;
        endcase
    end

    // Sub-word store: keep the upper bytes read back in RD.
    assign w_merge_data = (r_size == 2'b00) ? {mem_data_out[31:8], r_wdata[7:0]}
                                            : {mem_data_out[31:16], r_wdata[15:0]};

    // Control FSM. Every output is a flop, so the write enable clears
    // asynchronously the moment reset asserts, even in the middle of WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_wdata        <= 32'h0;
            r_req_ready    <= 1'b1;
            r_resp_valid   <= 1'b0;
            r_resp_fault   <= 1'b0;
            r_resp_rdata   <= 32'h0;
            r_mem_address  <= 32'h0;
            r_mem_data_in  <= 32'h0;
            r_mem_w_enable <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_write       <= req_write;
                        r_size        <= req_size;
                        r_unsigned    <= req_unsigned;
                        r_wdata       <= req_wdata;
                        r_mem_address <= req_addr;
                        r_req_ready   <= 1'b0;
                        if (w_fault) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else if (req_write && (req_size == 2'b10)) begin
                            // Whole word: no read-back needed.
                            r_state        <= WR;
                            r_mem_w_enable <= 1'b1;
                            r_mem_data_in  <= req_wdata;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (r_write) begin
                        r_state        <= WR;
                        r_mem_w_enable <= 1'b1;
                        r_mem_data_in  <= w_merge_data;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                    end
                end
                WR: begin
                    r_state        <= RESP;
                    r_mem_w_enable <= 1'b0;
                    r_resp_valid   <= 1'b1;
                    r_resp_fault   <= 1'b0;
                    r_resp_rdata   <= 32'h0;
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= 32'h0;
                end
                default: begin
                    r_state        <= IDLE;
                    r_req_ready    <= 1'b1;
                    r_resp_valid   <= 1'b0;
                    r_resp_fault   <= 1'b0;
                    r_resp_rdata   <= 32'h0;
                    r_mem_w_enable <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_fault   = r_resp_fault;
    assign resp_rdata   = r_resp_rdata;
    assign mem_address  = r_mem_address;
    assign mem_data_in  = r_mem_data_in;
    assign mem_w_enable = r_mem_w_enable;

endmodule
